// File: rtl/bit_degisikligi.sv
// rtl/bit_degisikligi.sv - AES SubWord: four S-box lanes feeding a one-cycle output register

// One S-box lane: GF(2^8) inverse (x^254, so 0 maps to 0) followed by the AES affine transform.
module bit_degisikligi_lane (
   input  logic [7:0] byte_in,
   output logic [7:0] byte_out
);

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Shift-and-add multiply in GF(2^8).
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   logic [7:0] inv;
   logic [7:0] pw;

   // Inverse as x^(2+4+...+128) = x^254: square repeatedly and accumulate each power.
   always_comb begin
      inv = 8'h01;
      pw  = byte_in;
      for (int i = 1; i < 8; i++) begin
         pw  = gf_mul(pw, pw);
         inv = gf_mul(inv, pw);
      end
   end

   // Affine transform: XOR of the byte with its left rotations by 1..4, plus 0x63.
   always_comb begin
      byte_out = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
   end

endmodule

module bit_degisikligi (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in_word,
   output logic        out_valid,
   output logic [31:0] out_word
);

   logic [31:0] sub_word;

   // Byte lanes are independent and stay in place; no rotation happens here.
   for (genvar k = 0; k < 4; k++) begin : g_lane
      bit_degisikligi_lane u_lane (
         .byte_in  (in_word[8*k +: 8]),
         .byte_out (sub_word[8*k +: 8])
      );
   end

   // Capture the substituted word on a valid strobe; the word holds when no strobe arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_word  <= 32'h0000_0000;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) out_word <= sub_word;
      end
   end

endmodule

// File: tb/tb_bit_degisikligi.sv
// tb/tb_bit_degisikligi.sv - directed and sweep checks of the AES SubWord stage
module tb_bit_degisikligi;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_word;
   logic        out_valid;
   logic [31:0] out_word;

   int checks = 0;
   int errors = 0;

   bit_degisikligi dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_word   (in_word),
      .out_valid (out_valid),
      .out_word  (out_word)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference multiply: polynomial product reduced by 0x11B, bit by bit.
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0000;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   // Reference S-box: inverse found by search, then the bitwise affine definition.
   function automatic logic [7:0] ref_sbox(input logic [7:0] x);
      logic [7:0] inv;
      logic [7:0] c;
      logic [7:0] r;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
         if (x != 8'h00 && ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
      c = 8'h63;
      for (int i = 0; i < 8; i++)
         r[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
              ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      return r;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] w);
      return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] sweep_word(input int b);
      logic [7:0] v;
      v = 8'(b);
      return {v, v + 8'd85, v ^ 8'ha5, ~v};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_word  = 32'hFFFF_FFFF;

      #1;
      check("reset_word_t0", out_word, 32'h0);
      check("reset_valid_t0", 32'(out_valid), 32'h0);
      repeat (2) @(negedge clk);
      check("reset_word_clocked", out_word, 32'h0);
      check("reset_valid_clocked", 32'(out_valid), 32'h0);

      rst_n = 1'b1;
      @(negedge clk);
      check("first_after_release_word", out_word, 32'h1616_1616);
      check("first_after_release_valid", 32'(out_valid), 32'h1);

      in_word = 32'h193D_E3BE;
      @(negedge clk);
      check("fips_vector", out_word, 32'hD427_11AE);
      check("fips_valid", 32'(out_valid), 32'h1);
      in_word = 32'h0000_0000;
      @(negedge clk);
      check("zero_word", out_word, 32'h6363_6363);
      check("zero_valid", 32'(out_valid), 32'h1);

      in_valid = 1'b0;
      in_word  = 32'h1234_5678;
      @(negedge clk);
      check("idle_valid", 32'(out_valid), 32'h0);
      check("idle_hold", out_word, 32'h6363_6363);
      in_word = 32'hDEAD_BEEF;
      @(negedge clk);
      check("idle_hold_changed_input", out_word, 32'h6363_6363);

      in_valid = 1'b1;
      in_word  = 32'h0153_1020;
      @(negedge clk);
      check("lane_independence", out_word, 32'h7CED_CAB7);
      in_word = 32'h8000_0000;
      @(negedge clk);
      check("no_rotation", out_word, 32'hCD63_6363);
      check("no_rotation_valid", 32'(out_valid), 32'h1);

      for (int b = 0; b < 256; b++) begin
         in_word  = sweep_word(b);
         in_valid = 1'b1;
         @(negedge clk);
         check($sformatf("sweep_%0d", b), out_word, ref_word(sweep_word(b)));
         if (b == 128) begin
            rst_n = 1'b0;
            #1;
            check("midsweep_reset_word", out_word, 32'h0);
            check("midsweep_reset_valid", 32'(out_valid), 32'h0);
            @(negedge clk);
            check("midsweep_reset_held", out_word, 32'h0);
            rst_n = 1'b1;
         end
      end

      in_valid = 1'b0;
      @(negedge clk);
      check("end_valid_low", 32'(out_valid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
